if_id_pipe: RTL
===============

Name: if_id_pipe

Overview:
- Parametrised fetch-to-decode pipeline stage that carries the PC and instruction word from IF to ID.
- Replaces the plain always-load register with a valid/ready handshake and an optional 2-entry skid buffer, so ID back-pressure never drops or duplicates a fetched instruction.
- Adds a synchronous flush for branch/exception redirect and a saturating stall-cycle counter for performance debug.

Parameters:
- ADDR_W, 32: width of the PC field.
- INST_W, 32: width of the instruction field.
- SKID, 1: 1 selects the 2-entry skid buffer with a registered in_ready; 0 selects a single entry with a combinational in_ready.
- NOP_INST, 0: instruction value driven on out_inst while out_valid=0.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discards every held and incoming entry.
- in_valid  in  1  IF presents a valid pc/inst.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  ADDR_W  fetched PC.
- in_inst  in  INST_W  fetched instruction.
- out_valid  out  1  entry presented to ID.
- out_ready  in  1  ID consumes the entry this cycle.
- out_pc  out  ADDR_W  PC to ID.
- out_inst  out  INST_W  instruction to ID.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, and has priority over every other input.
- Reset values: out_valid=0, out_pc=0, out_inst=NOP_INST, stall_cnt=0, skid entry empty. in_ready=0 while rst=1.
- Accept and consume: an entry is accepted when in_valid&&in_ready and consumed when out_valid&&out_ready. Order is strictly FIFO.
- Latency: an accepted entry reaches out_* on the next edge if the stage was empty, or if it was holding one entry and that entry is being consumed.
- SKID=1 states:
  - EMPTY: in_ready=1. Accept goes to ONE.
  - ONE (main reg valid): in_ready=1.
    - Accept with no consume goes to TWO; the new entry goes to the skid reg.
    - Accept with consume stays ONE; the new entry goes to the main reg.
    - Consume with no accept goes to EMPTY.
  - TWO: in_ready=0.
    - Consume moves the skid entry to the main reg and goes to ONE.
    - No consume stays TWO.
  - in_ready is a register output: a function of the state only, with no combinational path from out_ready.
- SKID=0: single register, in_ready = !out_valid || out_ready (combinational). Accept with simultaneous consume replaces the entry with no bubble.
- Empty outputs: when out_valid=0, out_pc=0 and out_inst=NOP_INST. Stale data never appears on the outputs.
- Held outputs: while out_valid=1 and out_ready=0, out_pc and out_inst hold stable.
- flush=1 (rst=0): on the next edge the state goes to EMPTY, out_valid=0 and outputs return to their empty values. Any entry accepted in the flush cycle is discarded. in_ready follows the normal rule during the flush cycle, so IF sees a completed handshake. flush does not clear stall_cnt.
- stall_cnt: increments each edge where out_valid=1, out_ready=0 and flush=0. It saturates at 2^CNT_W-1 and never wraps. Cleared only by rst.
- Simultaneous events:
  - rst with flush: reset wins (identical result).
  - flush with consume: the consume still counts at ID, but the stage empties.
  - Consume in TWO with in_valid=1: the input is not accepted because in_ready=0.
- Reset mid-operation: all held entries are lost. No handshake completes in a cycle where rst=1.

Test Plan:
- Streaming: SKID=1, rst released, out_ready=1, 8 back-to-back entries pc=0x100,0x104,... -> out_pc matches one cycle after each accept, in_ready stays 1, stall_cnt=0.
- Back-pressure: out_ready=0 after entry pc=0x200 is accepted, feed 0x204 and 0x208 -> 0x204 accepted into skid, in_ready=0 next cycle, 0x208 held at IF. Raise out_ready -> outputs 0x200,0x204,0x208 in order with no loss; stall_cnt equals the stalled cycle count.
- Flush in TWO: flush=1 with in_valid=1 pc=0x300 -> next cycle out_valid=0, out_inst=NOP_INST, out_pc=0. 0x300 never appears. stall_cnt unchanged.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds 15.
- SKID=0 bubble-free: alternate out_ready 1/0 with continuous in_valid -> in_ready equals !out_valid||out_ready each cycle; every accepted entry appears exactly once.
- Reset mid-stream: rst=1 in state TWO -> next cycle out_valid=0, stall_cnt=0, in_ready=0 during rst and 1 the cycle after release.

Source files
------------

// File: rtl/if_id_pipe.sv
// rtl/if_id_pipe.sv - IF-to-ID pipeline stage with valid/ready handshake, optional skid entry, flush and stall counter
//
// Purpose:
//   Carries the fetched PC and instruction word from IF to ID. With SKID=1 a
//   second (skid) entry lets in_ready be a pure register output, so there is no
//   combinational path from out_ready back to IF. With SKID=0 a single entry is
//   used and in_ready is combinational, which still allows bubble-free
//   replace-on-consume.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous reset, active-high, highest priority
//   flush      in   1       discard every held and incoming entry
//   in_valid   in   1       IF presents a valid pc/inst
//   in_ready   out  1       stage can accept this cycle
//   in_pc      in   ADDR_W  fetched PC
//   in_inst    in   INST_W  fetched instruction
//   out_valid  out  1       entry presented to ID
//   out_ready  in   1       ID consumes the entry this cycle
//   out_pc     out  ADDR_W  PC to ID (0 when empty)
//   out_inst   out  INST_W  instruction to ID (NOP_INST when empty)
//   stall_cnt  out  CNT_W   saturating count of cycles with out_valid & !out_ready

module if_id_pipe #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                SKID     = 1,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
    logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
    logic                rdy_q, rdy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept;
    logic                consume;

    // Handshake events. in_ready already folds in rst, so nothing is
    // accepted while the stage is being reset.
    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            pc_q        <= '0;
            inst_q      <= NOP_INST;
            skid_pc_q   <= '0;
            skid_inst_q <= NOP_INST;
            rdy_q       <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            rdy_q       <= rdy_d;
            cnt_q       <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                // Without a skid entry in_ready is low whenever a held entry
                // is not being consumed, so accept-without-consume only
                // happens when SKID is enabled.
                if (accept && !consume) begin
                    state_d = (SKID != 0) ? ST_TWO : ST_ONE;
                end else if (!accept && consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Redirect wins over every handshake; an entry accepted in this
        // cycle is dropped along with everything already held.
        if (flush) begin
            state_d = ST_EMPTY;
        end

        // Main register: cleared whenever the stage ends up empty so stale
        // data can never leak onto the outputs.
        if (state_d == ST_EMPTY) begin
            pc_d   = '0;
            inst_d = NOP_INST;
        end else if (state_q == ST_TWO && consume) begin
            pc_d   = skid_pc_q;
            inst_d = skid_inst_q;
        end else if (accept && (state_q == ST_EMPTY || consume)) begin
            pc_d   = in_pc;
            inst_d = in_inst;
        end

        // Skid register catches the entry that arrives while ID stalls.
        if (state_q == ST_ONE && accept && !consume && !flush) begin
            skid_pc_d   = in_pc;
            skid_inst_d = in_inst;
        end

        // Registered ready: low only when both entries are occupied.
        rdy_d = (state_d != ST_TWO);

        if (out_valid && !out_ready && !flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        out_pc    = pc_q;
        out_inst  = inst_q;
        stall_cnt = cnt_q;
        if (SKID != 0) begin
            in_ready = rdy_q && !rst;
        end else begin
            in_ready = ((state_q == ST_EMPTY) || out_ready) && !rst;
        end
    end

endmodule
